tree_loader: RTL and testbench
==============================

TREE_LOADER -- requirements
Module: tree_loader

Interface
REQ-001 The parameters SHALL be as follows:
- W_ADDR, 10: node address width.
- W_N_DATA, 11: node data width.
- W_C_DATA, 10: node-count config width.
- W_REWARD, 11: expected-reward width.
- W_ACTION, 3: action width.
- FIFO_DEPTH, 4: record buffer entries.

REQ-002 The ports SHALL be as follows:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  record offered.
- in_ready  out  1  record accepted when in_valid && in_ready.
- in_kind  in  3  0 NODES, 1 PARENT, 2 REWARD, 3 ACTION, 4 WEIGHT, 5 START, 6-7 illegal.
- in_addr  in  W_ADDR  target node.
- in_data  in  W_N_DATA  record payload.
- tv_rst  out  1  evaluator restart pulse.
- tv_conf_nodes  out  1  node-count write strobe.
- tv_conf_data  out  W_C_DATA  node count.
- tv_mem_par  out  1  parent write strobe.
- tv_mem_rew  out  1  reward write strobe.
- tv_mem_act  out  1  action write strobe.
- tv_mem_weight  out  1  weight write strobe.
- tv_mem_addr  out  W_ADDR  write address.
- tv_mem_data  out  W_N_DATA  write data.
- tv_exp_change  in  1  evaluator result ready.
- tv_exp  in  W_REWARD  evaluator expected reward, two's complement.
- tv_act  in  W_ACTION  evaluator chosen action.
- res_valid  out  1  result offered.
- res_ready  in  1  result consumed when res_valid && res_ready.
- res_exp  out  W_REWARD  captured reward.
- res_act  out  W_ACTION  captured action.
- res_timeout  out  1  result produced by timeout.
- err_count  out  8  dropped-record count, saturating.

Function
REQ-003 in_ready SHALL equal "FIFO not full" in every state; accepted records enter the FIFO in order.
REQ-004 The FSM states SHALL be LOAD, KICK, WAIT and RESULT; the FIFO SHALL pop at most one entry per cycle, and only in LOAD.
REQ-005 A popped record SHALL drive its single registered strobe high for exactly one cycle, one cycle after the pop; an accept into an empty FIFO SHALL give tv output the cycle after the accepting edge.
REQ-006 All tv strobes, tv_mem_addr, tv_mem_data and tv_conf_data SHALL be 0 in every cycle with no strobe; at most one strobe SHALL be high per cycle.
REQ-007 NODES SHALL drive tv_conf_nodes with tv_conf_data = in_data[W_C_DATA-1:0] and latch node_count from the same value.
REQ-008 PARENT, REWARD, ACTION and WEIGHT SHALL map to tv_mem_par, tv_mem_rew, tv_mem_act and tv_mem_weight, carrying in_addr and in_data.
REQ-009 Kind 6-7, and any node write with in_addr >= node_count, SHALL be popped with no strobe and SHALL increment err_count, saturating at 255.
REQ-010 A popped START SHALL cause LOAD->KICK; KICK SHALL drive tv_rst=1 for exactly one cycle, then move to WAIT.
REQ-011 tv_exp_change SHALL be sampled only in WAIT; when it is 1, tv_exp and tv_act SHALL be captured and the FSM SHALL move to RESULT.
REQ-012 In RESULT, res_valid SHALL be 1 with res_exp, res_act and res_timeout held stable until res_ready; the handshake cycle SHALL return the FSM to LOAD, with res_valid 0 the next cycle.
REQ-013 Records accepted after START SHALL stay buffered until LOAD resumes; while the FIFO is full, in_ready SHALL be 0.

Reset
REQ-014 rst sampled high SHALL set the following the next cycle:
- FSM to LOAD.
- FIFO empty.
- node_count=0, err_count=0.
- All outputs 0, except in_ready=1.
REQ-015 rst in any state, including mid-WAIT, SHALL abandon the operation with no res_valid and no tv_rst.

Configuration
REQ-016 With TREE_LOADER_TIMEOUT_EN defined, parameter TIMEOUT (default 64) SHALL bound WAIT as follows:
- After TIMEOUT WAIT cycles without tv_exp_change, the FSM SHALL enter RESULT.
- That result SHALL have res_timeout=1, res_exp=0, res_act=0.
- The WAIT counter SHALL clear on entry to WAIT.
REQ-017 Without TREE_LOADER_TIMEOUT_EN, WAIT SHALL last indefinitely and res_timeout SHALL be tied to 0.

Verification
REQ-018 Node programming: NODES data 7, then PARENT (1,0),(2,0),(3,0),(4,1),(5,1),(6,1) back-to-back -> one tv_conf_nodes pulse with data 7, then six consecutive tv_mem_par pulses, addresses 1-6 with matching data.
REQ-019 Drop checks: REWARD addr 9 with node_count 7 -> no strobe, err_count=1; kind 7 -> err_count=2; WEIGHT addr 0 with data 128 -> tv_mem_weight pulse.
REQ-020 Full run: full 7-node program, then START; model raises tv_exp_change with exp=25, act=3'b001 five cycles after tv_rst -> tv_rst high exactly one cycle; res_valid with res_exp 25, res_act 1, held stable for 3 cycles with res_ready low.
REQ-021 Backpressure: START, then 5 records offered while WAIT is held -> exactly 4 accepted and in_ready=0; none emitted until the result handshake, then all 4 emitted in order.
REQ-022 Timeout: with the macro defined, START and no tv_exp_change -> res_valid 64 cycles after WAIT entry, res_timeout=1; without the macro, res_valid stays 0 for 200 cycles.
REQ-023 Reset in WAIT: rst for one cycle during WAIT -> next cycle all outputs 0 except in_ready=1, and no res_valid follows.

Source files
------------

// File: rtl/tree_loader.sv
// tree_loader
//
// Purpose:
//   Buffers configuration records for a tree evaluator and replays them as
//   single-cycle write strobes. A START record restarts the evaluator. The
//   block then waits for its result and offers the result on a valid/ready
//   port. While the evaluator runs, new records stay queued in a small FIFO.
//
// Optional feature:
//   TREE_LOADER_TIMEOUT_EN  when defined, parameter TIMEOUT bounds the wait
//                           for the evaluator result. An expired wait gives a
//                           result with res_timeout=1 and a zero payload.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   record handshake
//   in_kind/in_addr/in_data   record contents
//                       kinds: 0 NODES, 1 PARENT, 2 REWARD, 3 ACTION,
//                       4 WEIGHT, 5 START
//   tv_rst              evaluator restart pulse
//   tv_conf_nodes/tv_conf_data   node-count write
//   tv_mem_par/rew/act/weight    node memory write strobes
//   tv_mem_addr/tv_mem_data      node memory write address and data
//   tv_exp_change/tv_exp/tv_act  evaluator result
//   res_valid/res_ready          result handshake
//   res_exp/res_act/res_timeout  captured result
//   err_count           count of dropped records, saturates at 255
module tree_loader #(
   parameter int W_ADDR     = 10,
   parameter int W_N_DATA   = 11,
   parameter int W_C_DATA   = 10,
   parameter int W_REWARD   = 11,
   parameter int W_ACTION   = 3,
   parameter int FIFO_DEPTH = 4
`ifdef TREE_LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 64
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_kind,
   input  logic [W_ADDR-1:0]   in_addr,
   input  logic [W_N_DATA-1:0] in_data,
   output logic                tv_rst,
   output logic                tv_conf_nodes,
   output logic [W_C_DATA-1:0] tv_conf_data,
   output logic                tv_mem_par,
   output logic                tv_mem_rew,
   output logic                tv_mem_act,
   output logic                tv_mem_weight,
   output logic [W_ADDR-1:0]   tv_mem_addr,
   output logic [W_N_DATA-1:0] tv_mem_data,
   input  logic                tv_exp_change,
   input  logic [W_REWARD-1:0] tv_exp,
   input  logic [W_ACTION-1:0] tv_act,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [W_REWARD-1:0] res_exp,
   output logic [W_ACTION-1:0] res_act,
   output logic                res_timeout,
   output logic [7:0]          err_count
);

   localparam int W_REC = 3 + W_ADDR + W_N_DATA;
   localparam int W_PTR = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int W_CNT = $clog2(FIFO_DEPTH + 1);

   localparam logic [2:0] K_NODES  = 3'd0;
   localparam logic [2:0] K_PARENT = 3'd1;
   localparam logic [2:0] K_REWARD = 3'd2;
   localparam logic [2:0] K_ACTION = 3'd3;
   localparam logic [2:0] K_WEIGHT = 3'd4;
   localparam logic [2:0] K_START  = 3'd5;

   typedef enum logic [1:0] {LOAD, KICK, WAIT, RESULT} state_t;

   state_t state, state_next;

   logic [W_REC-1:0]    fifo_mem [FIFO_DEPTH];
   logic [W_PTR-1:0]    rd_ptr, wr_ptr;
   logic [W_CNT-1:0]    count;
   logic                push, pop, fifo_write, fifo_read, head_valid;
   logic [W_REC-1:0]    head;
   logic [2:0]          head_kind;
   logic [W_ADDR-1:0]   head_addr;
   logic [W_N_DATA-1:0] head_data;
   logic                addr_ok;

   logic [W_C_DATA-1:0] node_count;

   logic                nxt_conf_nodes, nxt_par, nxt_rew, nxt_act, nxt_weight;
   logic [W_C_DATA-1:0] nxt_conf_data;
   logic [W_ADDR-1:0]   nxt_addr;
   logic [W_N_DATA-1:0] nxt_data;
   logic                drop, load_nodes;

`ifdef TREE_LOADER_TIMEOUT_EN
   localparam int W_TO = $clog2(TIMEOUT + 1);
   logic [W_TO-1:0]     wait_cnt;
   logic                timeout_hit;
   assign timeout_hit = (state == WAIT) && !tv_exp_change
                        && (wait_cnt == W_TO'(TIMEOUT - 1));
`else
   assign res_timeout = 1'b0;
`endif

   function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
      return (p == W_PTR'(FIFO_DEPTH - 1)) ? '0 : p + W_PTR'(1);
   endfunction

   // When the FIFO is empty the incoming record is the head itself, so an
   // accept in LOAD is decoded on the same edge and shows up one cycle later.
   assign in_ready   = (count != W_CNT'(FIFO_DEPTH));
   assign push       = in_valid && in_ready;
   assign head_valid = (count != '0) || push;
   assign head       = (count != '0) ? fifo_mem[rd_ptr] : {in_kind, in_addr, in_data};
   assign {head_kind, head_addr, head_data} = head;
   assign pop        = (state == LOAD) && head_valid;
   assign fifo_read  = pop && (count != '0);
   assign fifo_write = push && !(pop && (count == '0));
   assign addr_ok    = 32'(head_addr) < 32'(node_count);

   assign tv_rst    = (state == KICK);
   assign res_valid = (state == RESULT);

   // FIFO storage has no reset; only the pointers and count need one.
   always_ff @(posedge clk) begin
      if (fifo_write) begin
         fifo_mem[wr_ptr] <= {in_kind, in_addr, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_write) wr_ptr <= ptr_inc(wr_ptr);
         if (fifo_read)  rd_ptr <= ptr_inc(rd_ptr);
         if (fifo_write && !fifo_read)      count <= count + W_CNT'(1);
         else if (!fifo_write && fifo_read) count <= count - W_CNT'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   // Next-state logic: START leaves LOAD, the restart lasts one cycle, then
   // the evaluator result (or an expired wait) moves on to RESULT.
   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (pop && (head_kind == K_START)) state_next = KICK;
         KICK:    state_next = WAIT;
         WAIT: begin
            if (tv_exp_change) state_next = RESULT;
`ifdef TREE_LOADER_TIMEOUT_EN
            else if (timeout_hit) state_next = RESULT;
`endif
         end
         RESULT:  if (res_ready) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   // Output decode of the popped record into the next strobe values. Node
   // writes beyond the programmed node count and unknown kinds are dropped.
   always_comb begin
      nxt_conf_nodes = 1'b0;
      nxt_par        = 1'b0;
      nxt_rew        = 1'b0;
      nxt_act        = 1'b0;
      nxt_weight     = 1'b0;
      nxt_conf_data  = '0;
      nxt_addr       = '0;
      nxt_data       = '0;
      drop           = 1'b0;
      load_nodes     = 1'b0;
      if (pop) begin
         case (head_kind)
            K_NODES: begin
               nxt_conf_nodes = 1'b1;
               nxt_conf_data  = head_data[W_C_DATA-1:0];
               load_nodes     = 1'b1;
            end
            K_PARENT, K_REWARD, K_ACTION, K_WEIGHT: begin
               if (addr_ok) begin
                  nxt_par    = (head_kind == K_PARENT);
                  nxt_rew    = (head_kind == K_REWARD);
                  nxt_act    = (head_kind == K_ACTION);
                  nxt_weight = (head_kind == K_WEIGHT);
                  nxt_addr   = head_addr;
                  nxt_data   = head_data;
               end else begin
                  drop = 1'b1;
               end
            end
            K_START: begin
            end
            default: drop = 1'b1;
         endcase
      end
   end

   // Registered strobes, node count, error counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         tv_conf_nodes <= 1'b0;
         tv_mem_par    <= 1'b0;
         tv_mem_rew    <= 1'b0;
         tv_mem_act    <= 1'b0;
         tv_mem_weight <= 1'b0;
         tv_conf_data  <= '0;
         tv_mem_addr   <= '0;
         tv_mem_data   <= '0;
         node_count    <= '0;
         err_count     <= '0;
         res_exp       <= '0;
         res_act       <= '0;
      end else begin
         tv_conf_nodes <= nxt_conf_nodes;
         tv_mem_par    <= nxt_par;
         tv_mem_rew    <= nxt_rew;
         tv_mem_act    <= nxt_act;
         tv_mem_weight <= nxt_weight;
         tv_conf_data  <= nxt_conf_data;
         tv_mem_addr   <= nxt_addr;
         tv_mem_data   <= nxt_data;
         if (load_nodes) node_count <= nxt_conf_data;
         if (drop && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
         if ((state == WAIT) && tv_exp_change) begin
            res_exp <= tv_exp;
            res_act <= tv_act;
         end
`ifdef TREE_LOADER_TIMEOUT_EN
         else if (timeout_hit) begin
            res_exp <= '0;
            res_act <= '0;
         end
`endif
      end
   end

`ifdef TREE_LOADER_TIMEOUT_EN
   // Wait counter restarts during KICK so every WAIT starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         res_timeout <= 1'b0;
      end else begin
         if (state == KICK)      wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + W_TO'(1);
         if ((state == WAIT) && tv_exp_change) res_timeout <= 1'b0;
         else if (timeout_hit)                 res_timeout <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tree_loader.sv
// tb_tree_loader
//
// Purpose:
//   Self-checking bench for tree_loader. Records are issued by the stimulus
//   thread; a reference model predicts the resulting strobe sequence and
//   queues it. A monitor compares every strobe and result the DUT presents.
//   The evaluator is modelled by a process that answers each restart pulse
//   after a programmable delay. Honours TREE_LOADER_TIMEOUT_EN.
module tb_tree_loader;

   localparam int W_ADDR   = 10;
   localparam int W_N_DATA = 11;
   localparam int W_C_DATA = 10;
   localparam int W_REWARD = 11;
   localparam int W_ACTION = 3;

   localparam logic [2:0] K_NODES  = 3'd0;
   localparam logic [2:0] K_PARENT = 3'd1;
   localparam logic [2:0] K_REWARD = 3'd2;
   localparam logic [2:0] K_WEIGHT = 3'd4;
   localparam logic [2:0] K_START  = 3'd5;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_ready;
   logic [2:0]          in_kind;
   logic [W_ADDR-1:0]   in_addr;
   logic [W_N_DATA-1:0] in_data;
   logic                tv_rst, tv_conf_nodes, tv_mem_par, tv_mem_rew, tv_mem_act, tv_mem_weight;
   logic [W_C_DATA-1:0] tv_conf_data;
   logic [W_ADDR-1:0]   tv_mem_addr;
   logic [W_N_DATA-1:0] tv_mem_data;
   logic                tv_exp_change;
   logic [W_REWARD-1:0] tv_exp;
   logic [W_ACTION-1:0] tv_act;
   logic                res_valid, res_ready, res_timeout;
   logic [W_REWARD-1:0] res_exp;
   logic [W_ACTION-1:0] res_act;
   logic [7:0]          err_count;

   always #5 clk = ~clk;

   tree_loader dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
      .in_addr(in_addr), .in_data(in_data),
      .tv_rst(tv_rst), .tv_conf_nodes(tv_conf_nodes), .tv_conf_data(tv_conf_data),
      .tv_mem_par(tv_mem_par), .tv_mem_rew(tv_mem_rew), .tv_mem_act(tv_mem_act),
      .tv_mem_weight(tv_mem_weight), .tv_mem_addr(tv_mem_addr), .tv_mem_data(tv_mem_data),
      .tv_exp_change(tv_exp_change), .tv_exp(tv_exp), .tv_act(tv_act),
      .res_valid(res_valid), .res_ready(res_ready), .res_exp(res_exp),
      .res_act(res_act), .res_timeout(res_timeout), .err_count(err_count)
   );

   typedef struct {
      int                  code;
      logic [W_ADDR-1:0]   addr;
      logic [W_N_DATA-1:0] data;
   } tv_ev_t;

   typedef struct {
      logic [W_REWARD-1:0] exp_v;
      logic [W_ACTION-1:0] act_v;
      logic                to;
   } res_ev_t;

   tv_ev_t  tv_q[$];
   res_ev_t res_q[$];

   int tests_run = 0;
   int tests_failed = 0;
   int model_nodes = 0;
   int model_err = 0;
   int model_starts = 0;
   int tv_rst_seen = 0;
   int results_seen = 0;

   bit                  expect_quiet = 1'b0;
   bit                  eval_en = 1'b0;
   int                  eval_delay = 5;
   logic [W_REWARD-1:0] eval_exp = '0;
   logic [W_ACTION-1:0] eval_act = '0;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic report_fail(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got no event, expected one within bound", name);
   endtask

   // Reference model: records take effect in acceptance order.
   task automatic model_accept(input logic [2:0] k, input logic [W_ADDR-1:0] a, input logic [W_N_DATA-1:0] d);
      tv_ev_t e;
      e.addr = '0;
      e.data = '0;
      if (k == K_NODES) begin
         e.code = 0;
         e.data = W_N_DATA'(d % (1 << W_C_DATA));
         model_nodes = int'(d) % (1 << W_C_DATA);
         tv_q.push_back(e);
      end else if (k >= 3'd1 && k <= 3'd4) begin
         if (int'(a) < model_nodes) begin
            e.code = int'(k);
            e.addr = a;
            e.data = d;
            tv_q.push_back(e);
         end else if (model_err < 255) begin
            model_err++;
         end
      end else if (k == K_START) begin
         model_starts++;
      end else if (model_err < 255) begin
         model_err++;
      end
   endtask

   task automatic model_reset();
      tv_q.delete();
      res_q.delete();
      model_nodes = 0;
      model_err = 0;
   endtask

   // Offers one record and holds it until accepted.
   task automatic apply_stimulus(input logic [2:0] k, input logic [W_ADDR-1:0] a, input logic [W_N_DATA-1:0] d);
      int waited = 0;
      bit done = 1'b0;
      in_valid = 1'b1;
      in_kind  = k;
      in_addr  = a;
      in_data  = d;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(k, a, d);
            done = 1'b1;
         end else if (waited > 300) begin
            report_fail("accept_timeout");
            done = 1'b1;
         end
         waited++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_kind  = '0;
      in_addr  = '0;
      in_data  = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (tv_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (tv_q.size() != 0) report_fail({name, "_drain"});
      idle(3);
      check_output({name, "_err_count"}, 32'(err_count), 32'(model_err));
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      @(negedge clk);
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) report_fail({name, "_res_valid"});
   endtask

   task automatic wait_handshake(input string name, input int target);
      int n = 0;
      while (results_seen < target && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (results_seen < target) report_fail({name, "_handshake"});
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check_output({name, "_in_ready"}, 32'(in_ready), 32'd1);
      check_output({name, "_flags"},
                   32'({tv_rst, tv_conf_nodes, tv_mem_par, tv_mem_rew, tv_mem_act,
                        tv_mem_weight, res_valid, res_timeout}), 32'd0);
      check_output({name, "_bus"}, 32'({tv_conf_data, tv_mem_addr}), 32'd0);
      check_output({name, "_data"}, 32'({tv_mem_data, res_act}), 32'd0);
      check_output({name, "_res_err"}, 32'({res_exp, err_count}), 32'd0);
   endtask

   // Evaluator model: answers each restart pulse after eval_delay cycles.
   initial begin
      tv_exp_change = 1'b0;
      tv_exp = '0;
      tv_act = '0;
      forever begin
         @(negedge clk);
         if (tv_rst && eval_en && !rst) begin
            repeat (eval_delay) @(posedge clk);
            #1;
            tv_exp_change = 1'b1;
            tv_exp = eval_exp;
            tv_act = eval_act;
            res_q.push_back('{exp_v: eval_exp, act_v: eval_act, to: 1'b0});
            @(posedge clk);
            #1;
            tv_exp_change = 1'b0;
            tv_exp = '0;
            tv_act = '0;
         end
      end
   end

   // Monitor: compares every strobe and every result handshake.
   logic        prev_tv_rst = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [31:0] held_res = '0;

   always @(negedge clk) begin
      logic [4:0] s;
      tv_ev_t     e;
      res_ev_t    r;
      int         code;
      s = {tv_conf_nodes, tv_mem_par, tv_mem_rew, tv_mem_act, tv_mem_weight};
      if (!rst) begin
         check_output("strobe_onehot", 32'($countones(s) <= 1), 32'd1);
         if (s == 5'd0) begin
            check_output("idle_bus_zero", 32'({tv_mem_addr, tv_mem_data, tv_conf_data}), 32'd0);
         end else begin
            check_output("quiet_window", 32'(expect_quiet), 32'd0);
            code = s[4] ? 0 : s[3] ? 1 : s[2] ? 2 : s[1] ? 3 : 4;
            if (tv_q.size() == 0) begin
               check_output("unexpected_strobe", 32'(code), 32'hFFFF_FFFF);
            end else begin
               e = tv_q.pop_front();
               check_output("tv_kind", 32'(code), 32'(e.code));
               if (code == 0)
                  check_output("tv_conf_data", 32'(tv_conf_data), 32'(e.data[W_C_DATA-1:0]));
               else
                  check_output("tv_addr_data", 32'({tv_mem_addr, tv_mem_data}), 32'({e.addr, e.data}));
            end
         end
         if (tv_rst) begin
            check_output("tv_rst_width", 32'(prev_tv_rst), 32'd0);
            tv_rst_seen++;
         end
         if (res_valid) begin
            if (prev_valid && !prev_ready)
               check_output("res_stable", 32'({res_exp, res_act, res_timeout}), held_res);
            held_res = 32'({res_exp, res_act, res_timeout});
            if (res_ready) begin
               results_seen++;
               expect_quiet = 1'b0;
               if (res_q.size() == 0) begin
                  check_output("unexpected_result", held_res, 32'hFFFF_FFFF);
               end else begin
                  r = res_q.pop_front();
                  check_output("res_payload", held_res, 32'({r.exp_v, r.act_v, r.to}));
               end
            end
         end
      end
      prev_tv_rst = tv_rst && !rst;
      prev_valid  = res_valid && !rst;
      prev_ready  = res_ready;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected end of run");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int target;
      bit seen;
      int n;
      logic [2:0] k;
      logic [W_N_DATA-1:0] d5;

      rst = 1'b1;
      in_valid = 1'b0;
      in_kind = '0;
      in_addr = '0;
      in_data = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset");

      // Node programming, one record per cycle.
      apply_stimulus(K_NODES, 10'd0, 11'd7);
      check_output("nodes_latency", 32'(tv_conf_nodes), 32'd1);
      for (int i = 1; i <= 6; i++) begin
         apply_stimulus(K_PARENT, W_ADDR'(i), (i <= 3) ? 11'd0 : 11'd1);
         check_output("parent_back_to_back", 32'(tv_mem_par), 32'd1);
      end
      drain("program");

      // Drops and a boundary write at address 0.
      apply_stimulus(K_REWARD, 10'd9, 11'h55);
      drain("drop_addr");
      check_output("err_after_addr_drop", 32'(err_count), 32'd1);
      apply_stimulus(3'd7, 10'd3, 11'd5);
      drain("drop_kind");
      check_output("err_after_kind_drop", 32'(err_count), 32'd2);
      apply_stimulus(K_WEIGHT, 10'd0, 11'd128);
      check_output("weight_latency", 32'(tv_mem_weight), 32'd1);
      drain("weight");

      // Full run with the result held under backpressure.
      eval_en = 1'b1;
      eval_delay = 5;
      eval_exp = 11'd25;
      eval_act = 3'b001;
      res_ready = 1'b0;
      target = results_seen + 1;
      apply_stimulus(K_START, '0, '0);
      wait_valid("full_run");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("res_hold_valid", 32'(res_valid), 32'd1);
      end
      res_ready = 1'b1;
      wait_handshake("full_run", target);
      drain("full_run");

      // Records offered while waiting stay buffered; the fifth is refused.
      eval_delay = 30;
      eval_exp = W_REWARD'($urandom);
      eval_act = W_ACTION'($urandom);
      target = results_seen + 1;
      apply_stimulus(K_START, '0, '0);
      expect_quiet = 1'b1;
      for (int i = 0; i < 4; i++)
         apply_stimulus(K_PARENT, W_ADDR'(i + 1), W_N_DATA'($urandom));
      d5 = W_N_DATA'($urandom);
      in_valid = 1'b1;
      in_kind = K_PARENT;
      in_addr = 10'd5;
      in_data = d5;
      @(negedge clk);
      check_output("fifo_full_ready", 32'(in_ready), 32'd0);
      apply_stimulus(K_PARENT, 10'd5, d5);
      wait_handshake("backpressure", target);
      drain("backpressure");

      // Randomized batches.
      for (int it = 0; it < 8; it++) begin
         if (it % 2 == 0) apply_stimulus(K_NODES, '0, W_N_DATA'($urandom_range(1, 12)));
         n = $urandom_range(3, 10);
         for (int j = 0; j < n; j++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 7)      k = 3'((r % 4) + 1);
            else if (r == 8) k = 3'($urandom_range(6, 7));
            else             k = K_NODES;
            if (k == K_NODES)
               apply_stimulus(k, '0, W_N_DATA'($urandom_range(0, 12)));
            else
               apply_stimulus(k, W_ADDR'($urandom_range(0, 15)), W_N_DATA'($urandom));
            idle($urandom_range(0, 2));
         end
         eval_delay = $urandom_range(1, 20);
         eval_exp = W_REWARD'($urandom);
         eval_act = W_ACTION'($urandom);
         res_ready = 1'b0;
         target = results_seen + 1;
         apply_stimulus(K_START, '0, '0);
         wait_valid("random");
         repeat ($urandom_range(0, 3)) @(negedge clk);
         res_ready = 1'b1;
         wait_handshake("random", target);
         res_ready = 1'b0;
         drain("random");
      end

      // Evaluator silent.
      eval_en = 1'b0;
      res_ready = 1'b1;
      apply_stimulus(K_START, '0, '0);
      n = 0;
      @(negedge clk);
      while (!tv_rst && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!tv_rst) report_fail("timeout_tv_rst");
      @(posedge clk);
`ifdef TREE_LOADER_TIMEOUT_EN
      res_q.push_back('{exp_v: '0, act_v: '0, to: 1'b1});
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check_output("timeout_not_early", 32'(seen), 32'd0);
      @(negedge clk);
      check_output("timeout_valid", 32'(res_valid), 32'd1);
      @(posedge clk);
      #1 res_ready = 1'b0;
      idle(2);
`else
      seen = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check_output("no_timeout", 32'(seen), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset_long_wait");
      res_ready = 1'b0;
`endif

      // Reset in the middle of a wait abandons the run.
      apply_stimulus(K_START, '0, '0);
      idle(10);
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset_in_wait");
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (res_valid || tv_rst) seen = 1'b1;
      end
      check_output("no_result_after_reset", 32'(seen), 32'd0);

      check_output("tv_rst_count", 32'(tv_rst_seen), 32'(model_starts));
      check_output("tv_queue_empty", 32'(tv_q.size()), 32'd0);
      check_output("res_queue_empty", 32'(res_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
